arm_mem: RTL

ARM_MEM -- requirements
Module: arm_mem

---
 rtl/arm_mem.sv | 137 +++++++++++++
 1 files changed

// File: rtl/arm_mem.sv
// Unified instruction/data memory for a small ARM core, with a streaming loader
// that fills the array and holds the CPU in reset until the program is in place.
module arm_mem #(
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           pc,
  output logic [31:0]           instr,
  input  logic [31:0]           alu_result,
  input  logic [31:0]           write_data,
  input  logic                  mem_write,
  output logic [31:0]           read_data,
  input  logic                  load_start,
  input  logic                  run_start,
  input  logic                  load_valid,
  input  logic [31:0]           load_data,
  input  logic                  load_last,
  output logic                  load_ready,
  output logic                  cpu_hold,
  output logic [DEPTH_LOG2:0]   load_count,
  output logic                  load_full
);

  localparam int Depth = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] CountMax  = (DEPTH_LOG2 + 1)'(Depth);
  localparam logic [DEPTH_LOG2:0] CountLast = (DEPTH_LOG2 + 1)'(Depth - 1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_e;

  state_e                state_q;
  logic [DEPTH_LOG2:0]   loadCount_q;
  logic                  cpuHold_q;
  logic                  loadReady_q;
  logic                  loadFull_q;
  logic [31:0]           mem_q [Depth];

  logic                  memWe_d;
  logic [DEPTH_LOG2-1:0] memIdx_d;
  logic [31:0]           memData_d;
  logic                  beatAccept;

  // Any address bit above the word index makes the access out of range.
  function automatic logic inRange(input logic [31:0] addr);
    return (addr >> (DEPTH_LOG2 + 2)) == 32'd0;
  endfunction

  assign instr     = inRange(pc) ? mem_q[pc[DEPTH_LOG2+1:2]] : 32'h0;
  assign read_data = inRange(alu_result) ? mem_q[alu_result[DEPTH_LOG2+1:2]] : 32'h0;

  assign beatAccept = load_valid && loadReady_q;

  // The loader owns the write port in LOAD; the CPU owns it only in RUN.
  always_comb begin
    memWe_d   = 1'b0;
    memIdx_d  = '0;
    memData_d = '0;
    if (beatAccept && (loadCount_q != CountMax)) begin
      memWe_d   = 1'b1;
      memIdx_d  = loadCount_q[DEPTH_LOG2-1:0];
      memData_d = load_data;
    end else if ((state_q == RUN) && mem_write && inRange(alu_result)) begin
      memWe_d   = 1'b1;
      memIdx_d  = alu_result[DEPTH_LOG2+1:2];
      memData_d = write_data;
    end
  end

  // Array contents deliberately survive reset so a reset mid-load keeps earlier words.
  always_ff @(posedge clk) begin
    if (memWe_d) begin
      mem_q[memIdx_d] <= memData_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      loadCount_q <= '0;
      cpuHold_q   <= 1'b1;
      loadReady_q <= 1'b0;
      loadFull_q  <= 1'b0;
    end else begin
      loadFull_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (load_start) begin
            state_q     <= LOAD;
            loadCount_q <= '0;
            cpuHold_q   <= 1'b1;
            loadReady_q <= 1'b1;
          end else if (run_start) begin
            state_q     <= RUN;
            cpuHold_q   <= 1'b0;
            loadReady_q <= 1'b0;
          end
        end
        LOAD: begin
          if (beatAccept) begin
            if (loadCount_q != CountMax) begin
              loadCount_q <= loadCount_q + 1'b1;
            end
            if (loadCount_q == CountLast) begin
              state_q     <= RUN;
              loadFull_q  <= 1'b1;
              cpuHold_q   <= 1'b0;
              loadReady_q <= 1'b0;
            end else if (load_last) begin
              state_q     <= RUN;
              cpuHold_q   <= 1'b0;
              loadReady_q <= 1'b0;
            end
          end
        end
        RUN: begin
          if (load_start) begin
            state_q     <= LOAD;
            loadCount_q <= '0;
            cpuHold_q   <= 1'b1;
            loadReady_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          cpuHold_q   <= 1'b1;
          loadReady_q <= 1'b0;
        end
      endcase
    end
  end

  assign cpu_hold   = cpuHold_q;
  assign load_ready = loadReady_q;
  assign load_full  = loadFull_q;
  assign load_count = loadCount_q;

endmodule
